// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit with HI/LO result registers. It resolves one
// bit per cycle: shift-add for multiply and restoring division for divide.
// Signed operands are reduced to magnitudes on entry. The signs are re-applied
// in a single FIX cycle before HI/LO are written.
//
// Build option:
//   MULDIV_DIV_EN  When defined, the divide datapath is present.
//                  When undefined, a divide start does not raise busy. It
//                  returns a done pulse one cycle later, leaves HI/LO
//                  unchanged, and div0 stays low.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request an operation (sampled only while idle)
//   op       00 mult, 01 multu, 10 div, 11 divu
//   a, b     multiplicand/dividend, multiplier/divisor
//   flush    cancel the operation in flight (wins over start)
//   wr_hi    write wr_data into HI
//   wr_lo    write wr_data into LO
//   wr_data  data for HI/LO writes
//   busy     operation in progress
//   done     one-cycle pulse when HI/LO hold a new result
//   div0     pulses with done when the divisor was zero
//   hi, lo   result registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg, done_reg, div0_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    // For mult, acc holds {partial product, remaining multiplier bits}.
    // For div, the low half holds the dividend bits shifting out and the
    // quotient bits shifting in.
    logic [2*WIDTH-1:0] acc_reg;
    // For mult, opnd holds |multiplicand|. For div, it holds |divisor|.
    logic [WIDTH-1:0]   opnd_reg;
    logic               neg_q_reg;   // product or quotient is negative

    // Operand magnitudes. Only the signed ops (op[0] == 0) take absolute values.
    logic               signed_op;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               accept;

    assign signed_op = ~op[0];
    assign a_abs = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the carry back in.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                                 : {1'b0, acc_reg[2*WIDTH-1:1]};
    assign prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;

`ifdef MULDIV_DIV_EN
    logic               op_div_reg;
    logic               neg_r_reg;   // remainder takes the dividend's sign
    logic               b_zero_reg;
    logic [WIDTH-1:0]   a_raw_reg;   // returned untouched in HI on divide by zero
    logic [WIDTH-1:0]   rem_reg;

    // Restoring step on a WIDTH+1 bit partial remainder. A clear borrow bit
    // means the trial subtraction fits and the quotient bit is 1.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign div_shift = {rem_reg, acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign quo_fix   = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    assign rem_fix   = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

    assign accept = (state_reg == IDLE) && start && !flush;
`else
    // Without the divider, only multiply ops enter the iterative path.
    assign accept = (state_reg == IDLE) && start && !flush && !op[1];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            neg_q_reg  <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div_reg <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            a_raw_reg  <= '0;
            rem_reg    <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            div0_reg <= 1'b0;

            // Direct writes apply in any state. A result written in FIX
            // appears later in this block and therefore takes precedence.
            if (wr_hi) hi_reg <= wr_data;
            if (wr_lo) lo_reg <= wr_data;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        neg_q_reg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        op_div_reg <= op[1];
                        neg_r_reg  <= signed_op & a[WIDTH-1];
                        b_zero_reg <= (b == '0);
                        a_raw_reg  <= a;
                        rem_reg    <= '0;
                        if (op[1]) begin
                            acc_reg  <= {{WIDTH{1'b0}}, a_abs};
                            opnd_reg <= b_abs;
                        end else begin
                            acc_reg  <= {{WIDTH{1'b0}}, b_abs};
                            opnd_reg <= a_abs;
                        end
`else
                        acc_reg  <= {{WIDTH{1'b0}}, b_abs};
                        opnd_reg <= a_abs;
`endif
                    end
`ifndef MULDIV_DIV_EN
                    else if (start && !flush && op[1]) begin
                        // A divide request is acknowledged without doing any work.
                        done_reg <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    if (flush) begin
                        busy_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
`ifdef MULDIV_DIV_EN
                        if (op_div_reg) begin
                            acc_reg <= {acc_reg[2*WIDTH-1:WIDTH],
                                        acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
                            rem_reg <= div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                                       : div_diff[WIDTH-1:0];
                        end else begin
                            acc_reg <= mul_next;
                        end
`else
                        acc_reg <= mul_next;
`endif
                    end
                end
                FIX: begin
                    busy_reg <= 1'b0;
                    if (!flush) begin
                        done_reg <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (op_div_reg) begin
                            if (b_zero_reg) begin
                                hi_reg   <= a_raw_reg;
                                lo_reg   <= '1;
                                div0_reg <= 1'b1;
                            end else begin
                                hi_reg <= rem_fix;
                                lo_reg <= quo_fix;
                            end
                        end else
`endif
                        begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: busy_reg <= 1'b0;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign div0 = div0_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed testbench for muldiv_unit at WIDTH=32. Every expected value below
// was worked out by hand. The divide vectors are compiled only when
// MULDIV_DIV_EN is defined. Without that macro, the bench checks the
// divide-request acknowledge behaviour instead.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a start for one cycle. Returns 1 time unit after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, with a bound of 40 edges.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] o,
                             input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                             input logic exp_div0);
        int cyc;
        issue(o, x, y);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        wait_done(cyc);
        chk({tag, ".latency"}, 64'(cyc), 64'd33);
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, ".div0"}, 64'(div0), 64'(exp_div0));
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, ".done_once"}, 64'(done), 64'd0);
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h div0=%0d", tag, o, x, y, hi, lo, div0);
    endtask

    initial begin
        int  cyc;
        logic seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.div0", 64'(div0), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset released");

        // Signed versus unsigned multiply
        run_check("mult", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_check("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

`ifdef MULDIV_DIV_EN
        run_check("div", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("divu", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
        run_check("divu0", 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        run_check("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
`else
        // Without the divider, a divide request is acknowledged one cycle
        // later and leaves the multu result (hi=1, lo=FFFFFFFE) in place.
        issue(2'b11, 32'h0000_0007, 32'h0000_0002);
        chk("nodiv.busy", 64'(busy), 64'd0);
        chk("nodiv.done", 64'(done), 64'd1);
        chk("nodiv.div0", 64'(div0), 64'd0);
        chk("nodiv.hi", 64'(hi), 64'h0000_0001);
        chk("nodiv.lo", 64'(lo), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;
        chk("nodiv.done_once", 64'(done), 64'd0);
        $display("txn nodiv divu -> done=1 hi=%h lo=%h", hi, lo);
`endif

        // Direct HI/LO writes while idle
        @(negedge clk);
        wr_hi = 1'b1;
        wr_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        chk("wrhi", 64'(hi), 64'h1234_5678);
        @(negedge clk);
        wr_lo = 1'b1;
        wr_data = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        chk("wrlo", 64'(lo), 64'h9ABC_DEF0);
        $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

        // Flush mid-run: no done, and HI/LO keep the written values
        issue(2'b00, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("flush.no_done", 64'(seen), 64'd0);
        chk("flush.hi", 64'(hi), 64'h1234_5678);
        chk("flush.lo", 64'(lo), 64'h9ABC_DEF0);
        $display("txn flush mult -> hi=%h lo=%h", hi, lo);

        // A second start while busy is ignored
        issue(2'b01, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b00;
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        chk("ignore.done", 64'(done), 64'd1);
        chk("ignore.hi", 64'(hi), 64'd0);
        chk("ignore.lo", 64'(lo), 64'd12);
        $display("txn multu 3*4 with ignored start -> hi=%h lo=%h", hi, lo);

        // Back-to-back: the next start is presented during the done cycle
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("b2b1.latency", 64'(cyc), 64'd33);
        chk("b2b1.hi", 64'(hi), 64'd0);
        chk("b2b1.lo", 64'(lo), 64'd1);
        op = 2'b01;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b2.busy", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("b2b2.latency", 64'(cyc), 64'd33);
        chk("b2b2.hi", 64'(hi), 64'hFFFF_FFFE);
        chk("b2b2.lo", 64'(lo), 64'h0000_0001);
        $display("txn back-to-back mult/multu -> hi=%h lo=%h", hi, lo);

        // Reset asserted mid-run aborts at once
        issue(2'b00, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        $display("txn async reset mid-run");
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
